apb_master: RTL and testbench

- APB requester bridging a simple valid/ready command port onto an APB bus.
- Serves the APB slave memory block and any other APB slaves on the same bus.
- Sequences IDLE -> SETUP -> ACCESS and waits on PREADY, with a bounded wait-state timeout.
- Returns one response per command: read data or timeout flag.

---
 rtl/apb_master_if.sv | 38 +++
 rtl/apb_master.sv | 129 ++++++++++++
 tb/tb_apb_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// apb_master_if: command/response port plus APB bus signals
// for the apb_master requester.
interface apb_master_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_timeout;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: valid/ready command port to APB requester
// with a bounded wait-state timeout.
module apb_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input logic          PCLK,
  input logic          PRESETn,
  apb_master_if.master bus
);
  localparam int CW0 = $clog2(TIMEOUT + 1);
  localparam int CW  = (CW0 < 1) ? 1 : CW0;
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CLIM = CW'(LIM);
  localparam logic [CW-1:0] CMAX = '1;
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 psel_q, psel_d;
  logic                 pen_q, pen_d;
  logic                 pwr_q, pwr_d;
  logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic                 rv_q, rv_d;
  logic [DATAWIDTH-1:0] rd_q, rd_d;
  logic                 rto_q, rto_d;
  logic                 ready;

  assign ready = (state_q == IDLE) && PRESETn;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwr_d    = pwr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rv_d     = 1'b0;
    rd_d     = rd_q;
    rto_d    = rto_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready) begin
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pwr_d    = bus.cmd_write;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // success wins over a timeout landing on the same cycle
        if (bus.PREADY) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          rto_d   = 1'b0;
          rd_d    = pwr_q ? '0 : bus.PRDATA;
          state_d = IDLE;
        end else if (TO_EN && cnt_q == CLIM) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          rto_d   = 1'b1;
          rd_d    = '0;
          state_d = IDLE;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d  = 1'b0;
        pen_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
      rto_q    <= rto_d;
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = pen_q;
  assign bus.PWRITE      = pwr_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rv_q;
  assign bus.rsp_rdata   = rd_q;
  assign bus.rsp_timeout = rto_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed and random stimulus against a
// transaction-level APB requester model.
module tb_apb_master;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus();

  apb_master #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW),
    .TIMEOUT(TO)
  ) dut (
    .PCLK(clk),
    .PRESETn(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, a, e, $time);
    end
  endtask

  // simple slave memory; cleared while in reset
  logic [DW-1:0] mem [0:255];
  assign bus.PRDATA = mem[bus.PADDR];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
      mem[bus.PADDR] <= bus.PWDATA;
    end
  end

  // inputs as seen by the DUT at each rising edge
  logic          s_valid, s_write, s_ready;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  always @(posedge clk) begin
    s_valid <= bus.cmd_valid;
    s_write <= bus.cmd_write;
    s_addr  <= bus.cmd_addr;
    s_wdata <= bus.cmd_wdata;
    s_ready <= bus.PREADY;
    s_rdata <= bus.PRDATA;
  end

  // transaction-level model: bus phase + count of low-PREADY access cycles
  logic          m_psel, m_pen, m_pwrite, m_rv, m_rto;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_rd;
  int            m_low;

  task automatic respond(input logic to, input logic [DW-1:0] d);
    m_psel = 1'b0;
    m_pen  = 1'b0;
    m_rv   = 1'b1;
    m_rto  = to;
    m_rd   = d;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_psel = 0; m_pen = 0; m_pwrite = 0; m_rv = 0; m_rto = 0;
      m_paddr = '0; m_pwdata = '0; m_rd = '0; m_low = 0;
    end else begin
      m_rv = 1'b0;
      if (!m_psel) begin
        if (s_valid) begin
          m_psel = 1; m_pen = 0; m_pwrite = s_write;
          m_paddr = s_addr; m_pwdata = s_wdata; m_low = 0;
        end
      end else if (!m_pen) begin
        m_pen = 1'b1;
      end else if (s_ready) begin
        respond(1'b0, m_pwrite ? '0 : s_rdata);
      end else begin
        m_low++;
        if (TO > 0 && m_low == TO) respond(1'b1, '0);
      end
    end
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(!m_psel && rst_n));
    chk("PSEL", 64'(bus.PSEL), 64'(m_psel));
    chk("PENABLE", 64'(bus.PENABLE), 64'(m_pen));
    chk("PWRITE", 64'(bus.PWRITE), 64'(m_pwrite));
    chk("PADDR", 64'(bus.PADDR), 64'(m_paddr));
    chk("PWDATA", 64'(bus.PWDATA), 64'(m_pwdata));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rd));
    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(m_rto));
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // ticks until rsp_valid, counting PENABLE-high cycles
  task automatic wait_rsp(input string nm, output int pen_n);
    int k;
    pen_n = 0;
    k = 0;
    while (!bus.rsp_valid && k < 60) begin
      tick();
      if (bus.PENABLE) pen_n++;
      k++;
    end
    chk(nm, 64'(bus.rsp_valid), 64'd1);
  endtask

  int n;
  int bad;
  int idx, nrsp, cyc;
  int acc [3];
  logic [DW-1:0] rsp [3];
  logic          cw [3];
  logic [AW-1:0] ca [3];
  logic [DW-1:0] cd [3];
  logic          go;
  int            pct;

  initial begin
    bus.cmd_valid = 0; bus.cmd_write = 0;
    bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.PREADY = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_psel", 64'(bus.PSEL), 64'd0);

    // zero-wait write
    issue(1'b1, 8'h10, 32'hDEADBEEF);
    chk("wr_setup_psel", 64'(bus.PSEL), 64'd1);
    chk("wr_setup_pen", 64'(bus.PENABLE), 64'd0);
    tick();
    chk("wr_acc_pen", 64'(bus.PENABLE), 64'd1);
    chk("wr_acc_paddr", 64'(bus.PADDR), 64'h10);
    chk("wr_acc_pwdata", 64'(bus.PWDATA), 64'hDEADBEEF);
    tick();
    chk("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("wr_rsp_to", 64'(bus.rsp_timeout), 64'd0);
    chk("wr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("wr_rsp_psel", 64'(bus.PSEL), 64'd0);

    // read with three wait states
    bus.PREADY = 1'b0;
    issue(1'b0, 8'h10, '0);
    n = 0; bad = 0; cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      tick();
      cyc++;
      if (bus.PENABLE) begin
        n++;
        if (bus.PADDR != 8'h10) bad++;
        if (n == 4) bus.PREADY = 1'b1;
      end
    end
    chk("rd_wait_access_len", 64'(n), 64'd4);
    chk("rd_wait_paddr_stable", 64'(bad), 64'd0);
    chk("rd_wait_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);

    // timeout
    tick();
    bus.PREADY = 1'b0;
    issue(1'b0, 8'h20, '0);
    wait_rsp("to_resp", n);
    chk("to_pen_cycles", 64'(n), 64'(TO));
    chk("to_flag", 64'(bus.rsp_timeout), 64'd1);
    chk("to_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("to_psel", 64'(bus.PSEL), 64'd0);
    chk("to_ready", 64'(bus.cmd_ready), 64'd1);

    // back-to-back with cmd_valid held high
    bus.PREADY = 1'b1;
    cw[0] = 1; ca[0] = 8'h01; cd[0] = 32'h1234_5678;
    cw[1] = 0; ca[1] = 8'h01; cd[1] = 32'h0;
    cw[2] = 1; ca[2] = 8'h02; cd[2] = 32'hCAFE_F00D;
    idx = 0; nrsp = 0; cyc = 0; bad = 0;
    while (cyc < 40 && nrsp < 3) begin
      bus.cmd_valid = (idx < 3);
      if (idx < 3) begin
        bus.cmd_write = cw[idx];
        bus.cmd_addr  = ca[idx];
        bus.cmd_wdata = cd[idx];
      end
      go = bus.cmd_ready && (idx < 3);
      tick();
      cyc++;
      if (go) begin acc[idx] = cyc; idx++; end
      if (bus.PSEL && bus.cmd_ready) bad++;
      if (bus.rsp_valid) begin rsp[nrsp] = bus.rsp_rdata; nrsp++; end
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_rsp_count", 64'(nrsp), 64'd3);
    chk("b2b_gap01", 64'(acc[1] - acc[0]), 64'd3);
    chk("b2b_gap12", 64'(acc[2] - acc[1]), 64'd3);
    chk("b2b_read_back", 64'(rsp[1]), 64'h1234_5678);
    chk("b2b_ready_busy", 64'(bad), 64'd0);

    // command changes while busy are not taken
    tick();
    bus.PREADY = 1'b0;
    issue(1'b1, 8'h30, 32'h0BAD_F00D);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = i[0];
      bus.cmd_addr  = AW'($urandom_range(0, 255));
      tick();
      if (bus.PADDR != 8'h30) bad++;
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY = 1'b1;
    wait_rsp("busy_resp", n);
    tick();
    chk("busy_paddr_kept", 64'(bus.PADDR), 64'h30);
    chk("busy_paddr_stable", 64'(bad), 64'd0);
    chk("busy_idle", 64'(bus.PSEL), 64'd0);

    // reset during ACCESS
    bus.PREADY = 1'b0;
    issue(1'b0, 8'h10, '0);
    tick();
    chk("mid_rst_pen_before", 64'(bus.PENABLE), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 64'(bus.PSEL), 64'd0);
    chk("mid_rst_pen", 64'(bus.PENABLE), 64'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.rsp_valid) bad++;
    end
    chk("mid_rst_no_rsp", 64'(bad), 64'd0);
    bus.PREADY = 1'b1;
    issue(1'b0, 8'h10, '0);
    wait_rsp("post_rst_resp", n);
    chk("post_rst_to", 64'(bus.rsp_timeout), 64'd0);

    // random traffic; alternate slow and fast slaves
    for (int seg = 0; seg < 6; seg++) begin
      pct = seg[0] ? 96 : 35;
      for (int i = 0; i < 500; i++) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = AW'($urandom_range(0, 7));
        bus.cmd_wdata = $urandom;
        bus.PREADY    = ($urandom_range(0, 99) >= pct);
        tick();
      end
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
